usb_tx_engine: RTL and testbench
================================

# usb_tx_engine

USB full-speed packet transmitter and the transmit-side counterpart of the USB receive path. It accepts packet bytes from a byte-wide handshake and transmits the complete packet on the D+/D- lines: SYNC, PID, payload, optional CRC16, bit stuffing, NRZI encoding and EOP. It sits between the host-side transmit buffer/controller and the bus output drivers.

## Interface
- CLKS_PER_BIT, default 8: clk cycles per USB bit time; must be at least 2.
- clk  in  1  system clock.
- n_rst  in  1  asynchronous, active-low reset.
- tx_start  in  1  single-cycle request to send a packet.
  - Accepted only in IDLE and only when tx_data_valid=1; otherwise ignored.
- packet_type  in  1  sampled with tx_start.
  - 0: PID-only/handshake packet, no CRC.
  - 1: data packet; CRC16 is appended.
- tx_data  in  8  current byte from the source. The first byte is always the PID.
- tx_data_valid  in  1  tx_data holds a valid byte.
- tx_last  in  1  qualifies tx_data as the final byte of the packet.
- tx_data_req  out  1  one-cycle pulse: tx_data/tx_last were consumed this cycle, and the source must advance.
- d_plus_out  out  1  D+ line.
- d_minus_out  out  1  D- line.
- tx_busy  out  1  a packet is in progress.
- tx_done  out  1  one-cycle pulse when the EOP finishes.
- tx_error  out  1  one-cycle pulse on payload underrun.

## Operation
- FSM states: IDLE, SYNC, PID, DATA, CRC_LO, CRC_HI, EOP_SE0, EOP_J.
- IDLE, tx_start accepted:
  - PID is loaded from tx_data, and tx_last and packet_type are latched.
  - tx_data_req pulses.
  - FSM moves to SYNC.
- SYNC: transmits 0x80 LSB-first (seven 0s, then one 1).
- PID: transmits the PID byte LSB-first. At the end of the byte:
  - latched tx_last=1 and packet_type=0: go to EOP_SE0.
  - latched tx_last=1 and packet_type=1: go to CRC_LO (zero-length payload).
  - otherwise: load the next byte and go to DATA.
- DATA: at each byte boundary, the next byte is loaded from tx_data with a tx_data_req pulse.
  - If tx_data_valid=0 at the load edge, this is an underrun: pulse tx_error, abandon the packet and go to EOP_SE0.
  - A byte loaded with tx_last=1 is sent, then the FSM goes to CRC_LO. If packet_type=0, it goes to EOP_SE0 instead.
- CRC16 rules:
  - Polynomial x^16+x^15+x^2+1, preset 0xFFFF at tx_start.
  - Updated per payload bit (PID excluded), LSB-first, before stuffing.
  - The complemented remainder is transmitted, low byte then high byte, each LSB-first.
- Bit stuffing:
  - A counter counts consecutive 1 bits, starting at SYNC and running across byte boundaries through CRC_HI.
  - After the sixth consecutive 1, a 0 is inserted and the counter clears. Any 0 (data or stuffed) clears it.
  - A stuffed bit consumes one bit time. The shift register, CRC and byte counter hold during it.
  - No stuffing is applied in EOP.
- NRZI: a 0 bit toggles the line state (J<->K) and a 1 bit holds it.
  - J: d_plus_out=1, d_minus_out=0.
  - K: d_plus_out=0, d_minus_out=1.
  - Line state entering SYNC is J.
- EOP_SE0: drives both lines 0 for 2 bit times. EOP_J: drives J for 1 bit time, then the FSM returns to IDLE.
- Reset, including asynchronously mid-packet: FSM=IDLE, lines=J, tx_busy=0, tx_data_req=0, tx_done=0, tx_error=0, all counters and the CRC cleared. No EOP is sent.

## Timing
- The first SYNC bit appears on the lines the cycle after tx_start is accepted.
- Each bit, including stuffed bits, is held exactly CLKS_PER_BIT cycles.
- Line changes occur only on bit boundaries.
- Bytes are loaded on the clk edge that ends the last bit of the previous byte. tx_data_req is high in that same cycle.
- The source has 8*CLKS_PER_BIT cycles minimum to present the next byte.
- tx_busy:
  - Goes high the cycle after tx_start.
  - Stays high through the final EOP_J cycle.
  - Goes low in the same cycle tx_done pulses.
- tx_start while tx_busy=1 is ignored.

## Test plan
- ACK (packet_type=0, PID 0xD2, tx_last=1), CLKS_PER_BIT=8:
  - Line sequence is KJKJKJKK, then JJKJJKKK, then SE0 SE0 J.
  - 19 bit times = 152 cycles; tx_done after the last J.
  - Exactly one tx_data_req pulse.
- Zero-length DATA0 (PID 0xC3, tx_last=1, packet_type=1):
  - CRC bytes sent are 0x00, 0x00 (16 toggling bits), then EOP.
- DATA0 with payload ASCII "123456789":
  - CRC transmitted is 0xC8 then 0xB4.
  - Nine tx_data_req pulses after the PID pulse.
- Payload 0xFF, 0xFF:
  - A stuffed 0 (line toggle) follows every sixth 1, including across the byte boundary.
  - Total packet length is extended by the stuffed bits; the CRC still matches.
- Underrun: drop tx_data_valid at the second payload byte boundary.
  - Required response: tx_error pulse, then SE0 SE0 J, tx_done, return to IDLE.
- Assert n_rst low mid-DATA.
  - Outputs go immediately to J/idle values with all flags 0.
  - A following tx_start sends a clean packet.

Source files
------------

// File: rtl/usb_tx_engine.sv
// USB full-speed packet transmitter: serialises SYNC, PID, payload and CRC16 with
// bit stuffing and NRZI onto D+/D-, then closes the packet with SE0 SE0 J.
module usb_tx_engine #(
    parameter int unsigned CLKS_PER_BIT = 8
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       tx_start,
    input  logic       packet_type,
    input  logic [7:0] tx_data,
    input  logic       tx_data_valid,
    input  logic       tx_last,
    output logic       tx_data_req,
    output logic       d_plus_out,
    output logic       d_minus_out,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_error
);

    localparam int unsigned      CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [15:0]      CRC_POLY = 16'hA001;
    localparam logic [7:0]       SYNC_PAT = 8'h80;
    localparam logic [2:0]       MAX_ONES = 3'd6;

    typedef enum logic [2:0] {
        IDLE, SYNC, PID, DATA, CRC_LO, CRC_HI, EOP_SE0, EOP_J
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] clk_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;
    logic [7:0]       pid;
    logic [2:0]       ones_cnt;
    logic [15:0]      crc;
    logic             last_q;
    logic             ptype_q;
    logic             stuff_q;
    logic             eop_pend;

    logic             bit_end;
    state_t           adv_state;
    logic [7:0]       adv_shreg;
    logic [2:0]       adv_idx;
    logic             adv_last;
    logic             adv_load;
    logic             underrun;
    logic             to_eop;
    logic             go_eop;
    logic             go_stuff;
    logic             em_bit;
    logic             em_data;
    logic [15:0]      crc_next;

    assign bit_end = (clk_cnt == CNT_MAX);

    // Source of the next real bit once the current one ends, including byte hand-over.
    always_comb begin
        adv_state = state;
        adv_shreg = shreg;
        adv_idx   = bit_idx + 3'd1;
        adv_last  = last_q;
        adv_load  = 1'b0;
        underrun  = 1'b0;
        to_eop    = 1'b0;
        if (bit_idx == 3'd7) begin
            adv_idx = 3'd0;
            case (state)
                SYNC: begin
                    adv_state = PID;
                    adv_shreg = pid;
                end
                PID, DATA: begin
                    if (last_q) begin
                        if (ptype_q) begin
                            adv_state = CRC_LO;
                            adv_shreg = ~crc[7:0];
                        end else begin
                            to_eop = 1'b1;
                        end
                    end else if (!tx_data_valid) begin
                        underrun = 1'b1;
                    end else begin
                        adv_state = DATA;
                        adv_shreg = tx_data;
                        adv_last  = tx_last;
                        adv_load  = 1'b1;
                    end
                end
                CRC_LO: begin
                    adv_state = CRC_HI;
                    adv_shreg = ~crc[15:8];
                end
                default: to_eop = 1'b1;
            endcase
        end
    end

    // What goes on the line at this boundary; a pending stuffed bit resumes the held byte.
    always_comb begin
        go_eop   = stuff_q ? eop_pend : (underrun || (to_eop && ones_cnt != MAX_ONES));
        go_stuff = !stuff_q && !underrun && (ones_cnt == MAX_ONES);
        em_bit   = stuff_q ? shreg[bit_idx] : adv_shreg[adv_idx];
        em_data  = stuff_q ? (state == DATA) : (adv_state == DATA);
        crc_next = {1'b0, crc[15:1]} ^ ((crc[0] ^ em_bit) ? CRC_POLY : 16'h0000);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state       <= IDLE;
            clk_cnt     <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            pid         <= '0;
            ones_cnt    <= '0;
            crc         <= '0;
            last_q      <= 1'b0;
            ptype_q     <= 1'b0;
            stuff_q     <= 1'b0;
            eop_pend    <= 1'b0;
            d_plus_out  <= 1'b1;
            d_minus_out <= 1'b0;
            tx_busy     <= 1'b0;
            tx_done     <= 1'b0;
            tx_error    <= 1'b0;
            tx_data_req <= 1'b0;
        end else begin
            tx_data_req <= 1'b0;
            tx_done     <= 1'b0;
            tx_error    <= 1'b0;
            if (state != IDLE) begin
                clk_cnt <= bit_end ? '0 : clk_cnt + CNT_W'(1);
            end
            case (state)
                IDLE: begin
                    if (tx_start && tx_data_valid) begin
                        state       <= SYNC;
                        shreg       <= SYNC_PAT;
                        bit_idx     <= 3'd0;
                        pid         <= tx_data;
                        last_q      <= tx_last;
                        ptype_q     <= packet_type;
                        crc         <= 16'hFFFF;
                        ones_cnt    <= 3'd0;
                        stuff_q     <= 1'b0;
                        eop_pend    <= 1'b0;
                        clk_cnt     <= '0;
                        // First SYNC bit is a 0, so the idle J flips to K.
                        d_plus_out  <= 1'b0;
                        d_minus_out <= 1'b1;
                        tx_busy     <= 1'b1;
                        tx_data_req <= 1'b1;
                    end
                end
                EOP_SE0: begin
                    if (bit_end) begin
                        if (bit_idx == 3'd1) begin
                            state       <= EOP_J;
                            bit_idx     <= 3'd0;
                            d_plus_out  <= 1'b1;
                            d_minus_out <= 1'b0;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end
                end
                EOP_J: begin
                    if (bit_end) begin
                        state   <= IDLE;
                        tx_busy <= 1'b0;
                        tx_done <= 1'b1;
                    end
                end
                default: begin
                    if (bit_end) begin
                        stuff_q <= 1'b0;
                        if (!stuff_q) begin
                            state       <= adv_state;
                            shreg       <= adv_shreg;
                            bit_idx     <= adv_idx;
                            last_q      <= adv_last;
                            tx_data_req <= adv_load;
                        end
                        if (go_eop) begin
                            state       <= EOP_SE0;
                            bit_idx     <= 3'd0;
                            ones_cnt    <= 3'd0;
                            eop_pend    <= 1'b0;
                            d_plus_out  <= 1'b0;
                            d_minus_out <= 1'b0;
                            tx_error    <= underrun && !stuff_q;
                        end else if (go_stuff) begin
                            stuff_q     <= 1'b1;
                            eop_pend    <= to_eop;
                            ones_cnt    <= 3'd0;
                            d_plus_out  <= ~d_plus_out;
                            d_minus_out <= ~d_minus_out;
                        end else begin
                            if (!em_bit) begin
                                d_plus_out  <= ~d_plus_out;
                                d_minus_out <= ~d_minus_out;
                                ones_cnt    <= 3'd0;
                            end else begin
                                ones_cnt <= ones_cnt + 3'd1;
                            end
                            if (em_data) begin
                                crc <= crc_next;
                            end
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_usb_tx_engine.sv
// Bench for usb_tx_engine: cycle-by-cycle comparison against a bit-stream model of the
// packet, plus decoding of the captured line symbols against hand-computed bytes.
module tb_usb_tx_engine;

    localparam int CPB = 8;
    localparam logic [1:0] SYM_J   = 2'b10;
    localparam logic [1:0] SYM_K   = 2'b01;
    localparam logic [1:0] SYM_SE0 = 2'b00;

    typedef logic [7:0] byte_q_t [$];

    logic       clk = 1'b0;
    logic       n_rst;
    logic       tx_start;
    logic       packet_type;
    logic [7:0] tx_data;
    logic       tx_data_valid;
    logic       tx_last;
    logic       tx_data_req;
    logic       d_plus_out;
    logic       d_minus_out;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_error;

    int checks = 0;
    int errors = 0;

    byte_q_t    src;
    int         src_idx;
    int         drop_at;
    logic [1:0] exp_sym [$];
    bit         exp_req [0:4095];
    int         err_cyc;
    logic [1:0] got_sym [$];
    int         last_req;
    int         err_seen;
    int         done_at;
    logic [7:0] dec [$];
    int         dec_stuffs_early;
    bit         stuff_bad;
    string      ack_lit = "KJKJKJKKJJKJJKKKSSJ";

    usb_tx_engine #(.CLKS_PER_BIT(CPB)) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .tx_start      (tx_start),
        .packet_type   (packet_type),
        .tx_data       (tx_data),
        .tx_data_valid (tx_data_valid),
        .tx_last       (tx_last),
        .tx_data_req   (tx_data_req),
        .d_plus_out    (d_plus_out),
        .d_minus_out   (d_minus_out),
        .tx_busy       (tx_busy),
        .tx_done       (tx_done),
        .tx_error      (tx_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    function automatic logic [15:0] crc16(input byte_q_t q);
        logic [15:0] r = 16'hFFFF;
        foreach (q[i]) begin
            r = r ^ {8'h00, q[i]};
            for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
        end
        return ~r;
    endfunction

    function automatic logic [7:0] dec_at(input int i);
        return (i < dec.size()) ? dec[i] : 8'hEE;
    endfunction

    task automatic drive_src();
        if (src_idx < src.size()) begin
            tx_data       = src[src_idx];
            tx_last       = (src_idx == src.size() - 1);
            tx_data_valid = (src_idx != drop_at);
        end else begin
            tx_data       = 8'h00;
            tx_last       = 1'b0;
            tx_data_valid = 1'b0;
        end
    endtask

    // Logical bytes -> stuffed bit list -> NRZI symbols; request/error cycles from byte ends.
    task automatic build_model(input bit ptype);
        byte_q_t     lb;
        byte_q_t     pay;
        bit          bits [$];
        int          endpos [$];
        int          ones = 0;
        int          m;
        bit          under;
        bit          b;
        logic [15:0] c;
        logic [1:0]  line;
        under = (drop_at > 0) && (drop_at < src.size());
        m = under ? drop_at : src.size();
        for (int i = 1; i < m; i++) pay.push_back(src[i]);
        lb.push_back(8'h80);
        lb.push_back(src[0]);
        foreach (pay[i]) lb.push_back(pay[i]);
        if (ptype && !under) begin
            c = crc16(pay);
            lb.push_back(c[7:0]);
            lb.push_back(c[15:8]);
        end
        foreach (lb[j]) begin
            for (int k = 0; k < 8; k++) begin
                b = lb[j][k];
                bits.push_back(b);
                if (k == 7) endpos.push_back(bits.size() - 1);
                ones = b ? ones + 1 : 0;
                if (ones == 6) begin
                    bits.push_back(1'b0);
                    ones = 0;
                end
            end
        end
        if (under) begin
            while (bits.size() > endpos[m] + 1) void'(bits.pop_back());
        end
        for (int i = 0; i < 4096; i++) exp_req[i] = 1'b0;
        exp_req[0] = 1'b1;
        for (int j = 2; j <= m; j++) exp_req[(endpos[j-1] + 1) * CPB] = 1'b1;
        err_cyc = under ? (endpos[m] + 1) * CPB : -1;
        exp_sym.delete();
        line = SYM_J;
        foreach (bits[i]) begin
            if (!bits[i]) line = (line == SYM_J) ? SYM_K : SYM_J;
            exp_sym.push_back(line);
        end
        exp_sym.push_back(SYM_SE0);
        exp_sym.push_back(SYM_SE0);
        exp_sym.push_back(SYM_J);
    endtask

    task automatic run_packet(input bit ptype, input int abort_at, input bit poke_start);
        int         total;
        logic [5:0] got_v;
        logic [5:0] want_v;
        build_model(ptype);
        total = exp_sym.size() * CPB;
        got_sym.delete();
        last_req = 0;
        err_seen = 0;
        done_at  = -1;
        src_idx  = 0;
        drive_src();
        @(negedge clk);
        packet_type = ptype;
        tx_start    = 1'b1;
        for (int c = 0; c < total + 4; c++) begin
            @(negedge clk);
            tx_start = poke_start && (c == 40);
            want_v[5:4] = (c < total) ? exp_sym[c / CPB] : SYM_J;
            want_v[3]   = (c < total);
            want_v[2]   = (c == total);
            want_v[1]   = (c == err_cyc);
            want_v[0]   = (c < 4096) && exp_req[c];
            got_v = {d_plus_out, d_minus_out, tx_busy, tx_done, tx_error, tx_data_req};
            check($sformatf("cycle_%0d {dp,dm,busy,done,err,req}", c), 32'(got_v), 32'(want_v));
            if ((c % CPB) == CPB / 2 && c < total) got_sym.push_back({d_plus_out, d_minus_out});
            if (tx_data_req) begin
                last_req++;
                src_idx++;
                drive_src();
            end
            if (tx_done && done_at < 0) done_at = c;
            if (tx_error) err_seen++;
            if (c == abort_at) begin
                #2 n_rst = 1'b0;
                #1 check("async_reset_outputs", 32'({d_plus_out, d_minus_out, tx_busy, tx_done, tx_error, tx_data_req}), 32'(6'b100000));
                return;
            end
        end
    endtask

    // NRZI decode and destuff of the captured mid-bit samples; SYNC is dropped.
    task automatic decode();
        logic [1:0] prev = SYM_J;
        int         ones = 0;
        bit         raw [$];
        bit         b;
        logic [7:0] v;
        dec.delete();
        dec_stuffs_early = 0;
        stuff_bad = 1'b0;
        foreach (got_sym[i]) begin
            if (got_sym[i] == SYM_SE0) break;
            b = (got_sym[i] == prev);
            prev = got_sym[i];
            if (ones == 6) begin
                ones = 0;
                if (b) stuff_bad = 1'b1;
                if (raw.size() <= 32) dec_stuffs_early++;
                continue;
            end
            ones = b ? ones + 1 : 0;
            raw.push_back(b);
        end
        for (int i = 8; i + 8 <= raw.size(); i += 8) begin
            for (int k = 0; k < 8; k++) v[k] = raw[i + k];
            dec.push_back(v);
        end
    endtask

    task automatic check_ack_symbols(input string name);
        string s = "";
        foreach (got_sym[i]) begin
            case (got_sym[i])
                SYM_J:   s = {s, "J"};
                SYM_K:   s = {s, "K"};
                SYM_SE0: s = {s, "S"};
                default: s = {s, "X"};
            endcase
        end
        checks++;
        if (s != ack_lit) begin
            errors++;
            $display("FAIL %s: got %s expected %s", name, s, ack_lit);
        end
    endtask

    initial begin
        n_rst = 1'b0;
        tx_start = 1'b0;
        packet_type = 1'b0;
        tx_data = 8'h00;
        tx_data_valid = 1'b0;
        tx_last = 1'b0;
        drop_at = -1;
        repeat (3) @(negedge clk);
        check("in_reset_idle", 32'({d_plus_out, d_minus_out, tx_busy, tx_done, tx_error, tx_data_req}), 32'(6'b100000));
        n_rst = 1'b1;
        @(negedge clk);
        check("after_reset_idle", 32'({d_plus_out, d_minus_out, tx_busy, tx_done, tx_error, tx_data_req}), 32'(6'b100000));

        tx_data = 8'hD2;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        @(negedge clk);
        check("start_without_valid_ignored", 32'({tx_busy, d_plus_out, d_minus_out}), 32'(3'b010));

        src = '{8'hD2};
        run_packet(1'b0, -1, 1'b0);
        check_ack_symbols("ack_line_sequence");
        check("ack_done_cycle", 32'(done_at), 32'd152);
        check("ack_req_pulses", 32'(last_req), 32'd1);

        src = '{8'hC3};
        run_packet(1'b1, -1, 1'b0);
        decode();
        check("zlp_bytes", 32'(dec.size()), 32'd3);
        check("zlp_crc", 32'({dec_at(1), dec_at(2)}), 32'h0000);

        src = '{8'hC3, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        run_packet(1'b1, -1, 1'b1);
        decode();
        check("ascii_bytes", 32'(dec.size()), 32'd12);
        check("ascii_crc_lo", 32'(dec_at(10)), 32'hC8);
        check("ascii_crc_hi", 32'(dec_at(11)), 32'hB4);
        check("ascii_req_pulses", 32'(last_req), 32'd10);

        src = '{8'hC3, 8'hFF, 8'hFF};
        run_packet(1'b1, -1, 1'b0);
        decode();
        check("ff_payload", 32'({dec_at(1), dec_at(2)}), 32'hFFFF);
        check("ff_crc", 32'({dec_at(4), dec_at(3)}), 32'(crc16('{8'hFF, 8'hFF})));
        check("ff_stuffed_bits", 32'(dec_stuffs_early), 32'd3);
        check("ff_stuff_zero", 32'(stuff_bad), 32'd0);

        src = '{8'hC3, 8'h11, 8'h22, 8'h33};
        drop_at = 2;
        run_packet(1'b1, -1, 1'b0);
        decode();
        check("underrun_error_pulses", 32'(err_seen), 32'd1);
        check("underrun_req_pulses", 32'(last_req), 32'd2);
        check("underrun_bytes_sent", 32'(dec.size()), 32'd2);
        drop_at = -1;

        src = '{8'hC3, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        run_packet(1'b1, 300, 1'b0);
        repeat (2) @(negedge clk);
        check("held_reset_outputs", 32'({d_plus_out, d_minus_out, tx_busy, tx_done, tx_error, tx_data_req}), 32'(6'b100000));
        n_rst = 1'b1;
        @(negedge clk);
        src = '{8'hD2};
        run_packet(1'b0, -1, 1'b0);
        check_ack_symbols("post_reset_ack_sequence");
        check("post_reset_ack_done", 32'(done_at), 32'd152);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
